// File: rtl/data_mem.sv
// Purpose : single-port word-addressed data memory with sticky access-error flag
//           and an optional power-up zeroing sweep (macro DATA_MEM_INIT_CLEAR_EN).
// Latency : 1 cycle for loads (DRDATA registered); stores land at the request edge.
// Backpres: none; requests arriving while the sweep runs are dropped and flag ERR.
//
// Ports:
//   CLK       - clock, all state on rising edge
//   RSTN      - asynchronous active-low reset
//   DREQ      - access request
//   DRW       - 1 = store, 0 = load
//   DADDR     - 30-bit word address, bits above AW must be zero to be in range
//   DWDATA    - store data
//   DRDATA    - registered load data, held between accepted loads
//   INIT_DONE - array usable (tied high when the sweep is not built)
//   ERR       - sticky: out-of-range access or request during the sweep
//
// Assumes AW < 30 so that at least one upper address bit is checked.
module data_mem #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          DREQ,
  input  logic          DRW,
  input  logic [29:0]   DADDR,
  input  logic [DW-1:0] DWDATA,
  output logic [DW-1:0] DRDATA,
  output logic          INIT_DONE,
  output logic          ERR
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  logic          ready;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          acc_rd;
  logic          acc_wr;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [DW-1:0] wr_dat;

  assign in_range = (DADDR[29:AW] == '0);
  assign idx      = DADDR[AW-1:0];

  // Loads are accepted in or out of range (out of range returns zero);
  // stores only commit when in range.
  assign acc_rd = DREQ && ready && !DRW;
  assign acc_wr = DREQ && ready && DRW && in_range;

`ifdef DATA_MEM_INIT_CLEAR_EN
  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          sweep;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // READY is terminal; only reset brings the sweep back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sweep   = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep = 1'b1;
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign ready     = (state_q == ST_READY);
  assign INIT_DONE = ready;
`else
  assign ready     = 1'b1;
  assign INIT_DONE = 1'b1;
`endif

  // Single write port shared between the sweep and core stores.
  always_comb begin
    wr_en  = acc_wr;
    wr_idx = idx;
    wr_dat = DWDATA;
`ifdef DATA_MEM_INIT_CLEAR_EN
    if (sweep) begin
      wr_en  = 1'b1;
      wr_idx = cnt_q;
      wr_dat = '0;
    end
`endif
  end

  // Array is deliberately not reset; only the sweep clears it.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_dat;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      DRDATA <= '0;
    end else if (acc_rd) begin
      DRDATA <= in_range ? mem[idx] : '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ERR <= 1'b0;
    end else if (DREQ && (!ready || !in_range)) begin
      ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Purpose : directed self-checking bench for data_mem (AW=4 main instance,
//           AW=10 instance for the wide out-of-range case).
// Latency : checks DRDATA one edge after each request, sampled 1 time unit later.
// Backpres: n/a.
module tb_data_mem;

  logic        clk;
  logic        rstn, dreq, drw;
  logic [29:0] daddr;
  logic [31:0] dwdata, drdata;
  logic        init_done, err;

  logic        w_rstn, w_req, w_rw;
  logic [29:0] w_addr;
  logic [31:0] w_wdata, w_rdata;
  logic        w_done, w_err;

  int n_vec = 0;
  int n_err = 0;

`ifdef DATA_MEM_INIT_CLEAR_EN
  localparam logic SWEEP = 1'b1;
`else
  localparam logic SWEEP = 1'b0;
`endif

  data_mem #(.AW(4), .DW(32)) u_dut (
    .CLK(clk), .RSTN(rstn), .DREQ(dreq), .DRW(drw), .DADDR(daddr),
    .DWDATA(dwdata), .DRDATA(drdata), .INIT_DONE(init_done), .ERR(err)
  );

  data_mem #(.AW(10), .DW(32)) u_wide (
    .CLK(clk), .RSTN(w_rstn), .DREQ(w_req), .DRW(w_rw), .DADDR(w_addr),
    .DWDATA(w_wdata), .DRDATA(w_rdata), .INIT_DONE(w_done), .ERR(w_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one request for one cycle, then return 1 unit after the edge.
  task automatic op(input logic req, input logic rw, input logic [29:0] a, input logic [31:0] d);
    dreq = req; drw = rw; daddr = a; dwdata = d;
    tick(1);
    dreq = 1'b0;
  endtask

  task automatic w_op(input logic rw, input logic [29:0] a, input logic [31:0] d);
    w_req = 1'b1; w_rw = rw; w_addr = a; w_wdata = d;
    tick(1);
    w_req = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; dreq = 1'b0; drw = 1'b0; daddr = '0; dwdata = '0;
    w_rstn = 1'b0; w_req = 1'b0; w_rw = 1'b0; w_addr = '0; w_wdata = '0;
    #1;
    chk("rst_drdata", drdata, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_init_done", {31'b0, init_done}, {31'b0, !SWEEP});

    @(posedge clk); #1;
    rstn = 1'b1;

    if (SWEEP) begin
      // Loads during the sweep are dropped, flag ERR, and do not delay it.
      dreq = 1'b1; drw = 1'b0; daddr = 30'd5;
      tick(15);
      chk("init_busy_done", {31'b0, init_done}, 32'h0);
      chk("init_busy_drdata", drdata, 32'h0);
      chk("init_busy_err", {31'b0, err}, 32'h1);
      dreq = 1'b0;
      tick(1);
      chk("init_busy_rise16", {31'b0, init_done}, 32'h1);

      rstn = 1'b0; #1;
      chk("rst2_err", {31'b0, err}, 32'h0);
      chk("rst2_done", {31'b0, init_done}, 32'h0);
      @(posedge clk); #1;
      rstn = 1'b1;
      tick(15);
      chk("init_pre16", {31'b0, init_done}, 32'h0);
      tick(1);
      chk("init_rise16", {31'b0, init_done}, 32'h1);
      for (int i = 0; i < 16; i++) begin
        op(1'b1, 1'b0, 30'(i), 32'h0);
        chk($sformatf("sweep_zero_%0d", i), drdata, 32'h0);
      end
      chk("sweep_err", {31'b0, err}, 32'h0);
    end else begin
      op(1'b1, 1'b1, 30'd3, 32'h12345678);
      chk("nosweep_done0", {31'b0, init_done}, 32'h1);
      op(1'b1, 1'b0, 30'd3, 32'h0);
      chk("nosweep_rd3", drdata, 32'h12345678);
      chk("nosweep_done1", {31'b0, init_done}, 32'h1);
      chk("nosweep_err", {31'b0, err}, 32'h0);
    end

    // Store then load the same index on the next cycle.
    op(1'b1, 1'b1, 30'd5, 32'hDEADBEEF);
    op(1'b1, 1'b0, 30'd5, 32'h0);
    chk("rd5", drdata, 32'hDEADBEEF);
    chk("rd5_err", {31'b0, err}, 32'h0);

    // DRDATA holds across stores and idle cycles; idle inputs are ignored.
    op(1'b1, 1'b1, 30'd6, 32'h11111111);
    chk("hold_wr", drdata, 32'hDEADBEEF);
    op(1'b0, 1'b1, 30'd5, 32'h0);
    chk("hold_idle", drdata, 32'hDEADBEEF);
    op(1'b1, 1'b0, 30'd5, 32'h0);
    chk("idle_no_wr", drdata, 32'hDEADBEEF);
    op(1'b1, 1'b0, 30'd6, 32'h0);
    chk("rd6", drdata, 32'h11111111);

    // Last index and out-of-range aliasing onto index 0.
    op(1'b1, 1'b1, 30'd15, 32'h0000A5A5);
    op(1'b1, 1'b1, 30'd0, 32'h00000C0C);
    op(1'b1, 1'b0, 30'd15, 32'h0);
    chk("rd15", drdata, 32'h0000A5A5);
    chk("rd15_err", {31'b0, err}, 32'h0);
    op(1'b1, 1'b1, 30'h10, 32'hFFFFFFFF);
    chk("oor_wr_err", {31'b0, err}, 32'h1);
    op(1'b1, 1'b0, 30'd0, 32'h0);
    chk("oor_wr_nochg", drdata, 32'h00000C0C);
    op(1'b1, 1'b0, 30'h10, 32'h0);
    chk("oor_rd_zero", drdata, 32'h0);
    op(1'b1, 1'b0, 30'd15, 32'h0);
    chk("post_oor_rd", drdata, 32'h0000A5A5);
    chk("err_sticky", {31'b0, err}, 32'h1);

    // Mid-operation reset clears outputs immediately.
    rstn = 1'b0; #1;
    chk("rst3_drdata", drdata, 32'h0);
    chk("rst3_err", {31'b0, err}, 32'h0);
    chk("rst3_done", {31'b0, init_done}, {31'b0, !SWEEP});
    @(posedge clk); #1;
    rstn = 1'b1;

    if (SWEEP) begin
      // Abort the sweep at index 7, then a full sweep must follow.
      tick(7);
      rstn = 1'b0; #1;
      chk("rst4_done", {31'b0, init_done}, 32'h0);
      chk("rst4_err", {31'b0, err}, 32'h0);
      @(posedge clk); #1;
      rstn = 1'b1;
      tick(15);
      chk("resweep_pre16", {31'b0, init_done}, 32'h0);
      tick(1);
      chk("resweep_rise16", {31'b0, init_done}, 32'h1);
      op(1'b1, 1'b0, 30'd15, 32'h0);
      chk("resweep_rd15", drdata, 32'h0);
      op(1'b1, 1'b0, 30'd6, 32'h0);
      chk("resweep_rd6", drdata, 32'h0);
    end else begin
      // Reset alone does not clear the array.
      op(1'b1, 1'b0, 30'd15, 32'h0);
      chk("rst_keeps_mem", drdata, 32'h0000A5A5);
    end

    // Wide instance: address 0x400 is one past the top of a 1024-word array.
    w_rstn = 1'b1;
    for (int i = 0; i < 2000 && !w_done; i++) tick(1);
    chk("wide_ready", {31'b0, w_done}, 32'h1);
    w_op(1'b1, 30'h3FF, 32'h00000077);
    w_op(1'b0, 30'h3FF, 32'h0);
    chk("wide_rd3ff", w_rdata, 32'h00000077);
    chk("wide_err0", {31'b0, w_err}, 32'h0);
    w_op(1'b0, 30'h400, 32'h0);
    chk("wide_oor_zero", w_rdata, 32'h0);
    chk("wide_oor_err", {31'b0, w_err}, 32'h1);
    w_op(1'b0, 30'h3FF, 32'h0);
    chk("wide_rd_after", w_rdata, 32'h00000077);
    chk("wide_err_sticky", {31'b0, w_err}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
